// File: rtl/booth_mul_seq_if.sv
// Start/done handshake bundle for the sequential Booth multiplier.
// The requester drives operands and start; the multiplier returns busy, done and product.
interface booth_mul_seq_if #(
  parameter int WIDTH = 8
);
  logic                   start;
  logic [WIDTH-1:0]       mcand;
  logic [WIDTH-1:0]       mplier;
  logic                   tc;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output start, mcand, mplier, tc,
    input  busy, done, product
  );

  modport slave (
    input  start, mcand, mplier, tc,
    output busy, done, product
  );
endinterface

// File: rtl/booth_mul_seq.sv
// Radix-2 Booth multiplier retiring one step per clock; WIDTH+1 steps per operation,
// signed or unsigned operands chosen per operation by tc.
module booth_mul_seq #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  booth_mul_seq_if.slave bus
);
  localparam int             CW   = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH);

  typedef enum logic {IDLE, CALC} state_t;

  state_t                   state, state_nxt;
  logic                     accept, last_step;
  logic signed [WIDTH+1:0]  acc, acc_sum, acc_sh;
  logic        [WIDTH:0]    q, q_sh;
  logic                     q_1;
  logic signed [WIDTH:0]    m;
  logic        [CW-1:0]     cnt;
  logic [2*WIDTH-1:0]       product_r;
  logic                     done_r;

  // One extra operand bit lets unsigned values run through the signed Booth recurrence.
  function automatic logic signed [WIDTH:0] extend(input logic [WIDTH-1:0] v, input logic tc);
    return {tc & v[WIDTH-1], v};
  endfunction

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept    = 1'b1;
        state_nxt = CALC;
      end
      CALC: if (cnt == LAST) begin
        last_step = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // A is two bits wider than the operands so A +/- M never overflows before the shift.
  always_comb begin
    acc_sum = acc;
    case ({q[0], q_1})
      2'b01:   acc_sum = acc + {m[WIDTH], m};
      2'b10:   acc_sum = acc - {m[WIDTH], m};
      default: acc_sum = acc;
    endcase
    acc_sh = {acc_sum[WIDTH+1], acc_sum[WIDTH+1:1]};
    q_sh   = {acc_sum[0], q[WIDTH:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      q         <= '0;
      q_1       <= 1'b0;
      m         <= '0;
      product_r <= '0;
      done_r    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_r <= last_step;
      if (accept) begin
        m   <= extend(bus.mcand, bus.tc);
        acc <= '0;
        q   <= extend(bus.mplier, bus.tc);
        q_1 <= 1'b0;
        cnt <= '0;
      end else if (state == CALC) begin
        acc <= acc_sh;
        q   <= q_sh;
        q_1 <= q[0];
        cnt <= cnt + CW'(1);
      end
      // Product is taken from the final shifted value so it is never exposed mid-run.
      if (last_step) product_r <= {acc_sh[WIDTH-2:0], q_sh};
    end
  end

  assign bus.busy    = (state == CALC);
  assign bus.done    = done_r;
  assign bus.product = product_r;
endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq at WIDTH 4, 8 and 16 against an integer product model.
module tb_booth_mul_seq;
  logic clk = 1'b0;
  logic rst;
  int   ncmp = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  booth_mul_seq_if #(.WIDTH(4))  b4 ();
  booth_mul_seq_if #(.WIDTH(8))  b8 ();
  booth_mul_seq_if #(.WIDTH(16)) b16 ();

  booth_mul_seq #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(b4));
  booth_mul_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
  booth_mul_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: interpret operands per mode, multiply as integers, keep 2*w bits.
  function automatic logic [63:0] ref_mul(input longint a, input longint b, input bit tc, input int w);
    longint x, y, p;
    x = a;
    y = b;
    if (tc && a[w-1]) x = a - (longint'(1) << w);
    if (tc && b[w-1]) y = b - (longint'(1) << w);
    p = x * y;
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait8(output int n);
    logic [15:0] prev;
    prev = b8.product;
    n = 0;
    do begin
      tick();
      n++;
      if (!b8.done) begin
        chk("w8 hold", b8.product, prev);
        chk("w8 busy", b8.busy, 1);
      end
    end while (!b8.done && n < 40);
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic t, input logic [15:0] exp);
    int n;
    b8.mcand = a; b8.mplier = b; b8.tc = t; b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    chk({tag, " busy"}, b8.busy, 1);
    wait8(n);
    chk({tag, " lat"}, n, 9);
    chk({tag, " prod"}, b8.product, exp);
    chk({tag, " busy@done"}, b8.busy, 0);
    tick();
    chk({tag, " done1"}, b8.done, 0);
  endtask

  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic t, input logic [31:0] exp);
    int n;
    b16.mcand = a; b16.mplier = b; b16.tc = t; b16.start = 1'b1;
    tick();
    b16.start = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!b16.done && n < 60);
    chk({tag, " lat"}, n, 17);
    chk({tag, " prod"}, b16.product, exp);
    tick();
    chk({tag, " done1"}, b16.done, 0);
  endtask

  initial begin
    int n, dn;
    logic [7:0] ra, rb;
    logic rt;
    logic [8:0] p;

    rst = 1'b1;
    b4.start = 0;  b4.mcand = 0;  b4.mplier = 0;  b4.tc = 0;
    b8.start = 0;  b8.mcand = 0;  b8.mplier = 0;  b8.tc = 0;
    b16.start = 0; b16.mcand = 0; b16.mplier = 0; b16.tc = 0;
    tick(); tick();
    chk("rst busy8", b8.busy, 0);
    chk("rst done8", b8.done, 0);
    chk("rst prod8", b8.product, 0);
    chk("rst prod4", b4.product, 0);
    chk("rst prod16", b16.product, 0);
    rst = 1'b0;
    tick();

    run8("s80x80", 8'h80, 8'h80, 1'b1, 16'h4000);
    run8("uFFxFF", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    run8("sFFx7F", 8'hFF, 8'h7F, 1'b1, 16'hFF81);
    run8("uFFx7F", 8'hFF, 8'h7F, 1'b0, 16'h7E81);

    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rt = 1'($urandom);
      run8($sformatf("rnd%0d", i), ra, rb, rt, 16'(ref_mul(ra, rb, rt, 8)));
    end

    // Re-pulsed start and toggled operands while busy.
    b8.mcand = 8'h93; b8.mplier = 8'hC5; b8.tc = 1'b1; b8.start = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 5; i++) begin
      b8.mcand = 8'($urandom); b8.mplier = 8'($urandom); b8.tc = ~b8.tc; b8.start = 1'b1;
      tick();
      n++;
      chk("dist early", b8.done, 0);
    end
    b8.start = 1'b0;
    do begin tick(); n++; end while (!b8.done && n < 40);
    chk("dist lat", n, 9);
    chk("dist prod", b8.product, 16'(ref_mul(8'h93, 8'hC5, 1'b1, 8)));
    dn = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (b8.done) dn++; end
    chk("dist extra", dn, 0);

    // Reset at step 4 abandons the operation.
    b8.mcand = 8'h37; b8.mplier = 8'h59; b8.tc = 1'b0; b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid prod", b8.product, 0);
    chk("rstmid busy", b8.busy, 0);
    chk("rstmid done", b8.done, 0);
    dn = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (b8.done) dn++; end
    chk("rstmid nodone", dn, 0);
    chk("rstmid prod2", b8.product, 0);

    // Reset together with start.
    b8.mcand = 8'h12; b8.mplier = 8'h34; b8.start = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; b8.start = 1'b0;
    chk("rststart busy", b8.busy, 0);
    chk("rststart done", b8.done, 0);
    tick();
    chk("rststart busy2", b8.busy, 0);

    // Reset while done is high.
    b8.mcand = 8'hA5; b8.mplier = 8'h3C; b8.tc = 1'b1; b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    wait8(n);
    chk("rstdone seen", b8.done, 1);
    chk("rstdone prod", b8.product, 16'(ref_mul(8'hA5, 8'h3C, 1'b1, 8)));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstdone prod0", b8.product, 0);
    chk("rstdone done0", b8.done, 0);
    chk("rstdone busy0", b8.busy, 0);
    run8("after rst", 8'hC3, 8'h7E, 1'b1, 16'(ref_mul(8'hC3, 8'h7E, 1'b1, 8)));

    // WIDTH=4 exhaustive sweep, start held high throughout.
    p = 9'd0;
    b4.tc = p[8]; b4.mcand = p[7:4]; b4.mplier = p[3:0]; b4.start = 1'b1;
    tick();
    for (int k = 0; k < 512; k++) begin
      if (k < 511) begin
        p = 9'(k + 1);
        b4.tc = p[8]; b4.mcand = p[7:4]; b4.mplier = p[3:0];
      end else begin
        b4.start = 1'b0;
      end
      p = 9'(k);
      n = 0;
      do begin tick(); n++; end while (!b4.done && n < 20);
      chk($sformatf("sw4 lat %0d", k), n, 5);
      chk($sformatf("sw4 prod %0d", k), b4.product, 8'(ref_mul(p[7:4], p[3:0], p[8], 4)));
      if (k < 511) tick();
    end
    tick();

    run16("s8000x7FFF", 16'h8000, 16'h7FFF, 1'b1, 32'hC0008000);
    run16("uFFFFxFFFF", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
